// File: rtl/bilstm_fc_concat.sv
// Collects forward/backward BiLSTM hidden streams into the FC1 input vector,
// launches the FC chain with a one-cycle start pulse and holds until fc_done.
module bilstm_fc_concat #(
  parameter int DATA_WIDTH  = 16,
  parameter int HID_DIM     = 100,
  parameter int BWD_REVERSE = 0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fwd_valid,
  input  logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  fwd_ready,
  input  logic                  bwd_valid,
  input  logic [DATA_WIDTH-1:0] bwd_data,
  output logic                  bwd_ready,
  output logic [DATA_WIDTH-1:0] concat_vector [0:2*HID_DIM-1],
  output logic                  start_fc1,
  input  logic                  fc_done,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  vec_count
);

  localparam int VEC_LEN = 2 * HID_DIM;
  localparam int IDX_W   = $clog2(HID_DIM + 1);
  localparam int VIDX_W  = $clog2(VEC_LEN);

  typedef enum logic [1:0] {
    FILL,
    LAUNCH,
    WAIT_FC
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_fwd_cnt;
  logic [IDX_W-1:0]      r_bwd_cnt;
  logic [IDX_W-1:0]      w_fwd_cnt_nxt;
  logic [IDX_W-1:0]      w_bwd_cnt_nxt;
  logic [CNT_WIDTH-1:0]  r_vec_count;
  logic [DATA_WIDTH-1:0] r_vec [0:VEC_LEN-1];
  logic                  w_fwd_acc;
  logic                  w_bwd_acc;
  logic [VIDX_W-1:0]     w_fwd_idx;
  logic [VIDX_W-1:0]     w_bwd_idx;

  // NOTE: readies are decoded outside the FSM block so the accept strobes do
  // not feed back into the process that consumes them (no combinational loop).
  assign fwd_ready = (r_state == FILL) && (r_fwd_cnt < IDX_W'(HID_DIM));
  assign bwd_ready = (r_state == FILL) && (r_bwd_cnt < IDX_W'(HID_DIM));

  assign w_fwd_acc     = fwd_valid && fwd_ready;
  assign w_bwd_acc     = bwd_valid && bwd_ready;
  assign w_fwd_cnt_nxt = r_fwd_cnt + IDX_W'(w_fwd_acc);
  assign w_bwd_cnt_nxt = r_bwd_cnt + IDX_W'(w_bwd_acc);
  assign w_fwd_idx     = VIDX_W'(r_fwd_cnt);

  generate
    if (BWD_REVERSE != 0) begin : g_bwd_rev
      assign w_bwd_idx = VIDX_W'(VEC_LEN - 1) - VIDX_W'(r_bwd_cnt);
    end else begin : g_bwd_fwd
      assign w_bwd_idx = VIDX_W'(HID_DIM) + VIDX_W'(r_bwd_cnt);
    end
  endgenerate

  // NOTE: every combinational output gets a default before the case, so no
  // path through the block leaves a signal unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    start_fc1   = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      FILL: begin
        if ((w_fwd_cnt_nxt == IDX_W'(HID_DIM)) && (w_bwd_cnt_nxt == IDX_W'(HID_DIM)))
          w_state_nxt = LAUNCH;
      end
      LAUNCH: begin
        start_fc1   = 1'b1;
        busy        = 1'b1;
        w_state_nxt = WAIT_FC;
      end
      WAIT_FC: begin
        busy = 1'b1;
        if (fc_done) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FILL;
      r_fwd_cnt   <= '0;
      r_bwd_cnt   <= '0;
      r_vec_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == WAIT_FC) && fc_done) begin
        r_fwd_cnt <= '0;
        r_bwd_cnt <= '0;
      end else begin
        r_fwd_cnt <= w_fwd_cnt_nxt;
        r_bwd_cnt <= w_bwd_cnt_nxt;
      end
      if (r_state == LAUNCH) r_vec_count <= r_vec_count + CNT_WIDTH'(1);
    end
  end

  // NOTE: the vector storage is reset because a cleared FC1 input after reset
  // is part of the interface contract; between frames it is only overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VEC_LEN; i++) r_vec[i] <= '0;
    end else begin
      if (w_fwd_acc) r_vec[w_fwd_idx] <= fwd_data;
      if (w_bwd_acc) r_vec[w_bwd_idx] <= bwd_data;
    end
  end

  assign concat_vector = r_vec;
  assign vec_count     = r_vec_count;

endmodule

// File: doc/bilstm_fc_concat.md
Name: bilstm_fc_concat

Overview:
- Upstream stage of the FC head (FC1 200->100, FC2 100->3, Q4.12).
- Collects the forward and backward BiLSTM final hidden vectors. Each arrives as an independent element-serial valid/ready stream.
- Assembles them into the 2*HID_DIM-element FC1 input vector, holds that vector stable and pulses the FC start.
- Accepts no new hidden data until the FC chain reports completion.

Parameters:
- DATA_WIDTH, 16, element width in bits (Q4.12 signed).
- HID_DIM, 100, elements per direction; output vector length is 2*HID_DIM.
- BWD_REVERSE, 0. 1 = backward element k is stored at index 2*HID_DIM-1-k; 0 = it is stored at index HID_DIM+k.
- CNT_WIDTH, 16, width of the launched-vector counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- fwd_valid  in  1  forward hidden element valid.
- fwd_data  in  DATA_WIDTH  forward hidden element, signed.
- fwd_ready  out  1  forward element accepted when fwd_valid && fwd_ready.
- bwd_valid  in  1  backward hidden element valid.
- bwd_data  in  DATA_WIDTH  backward hidden element, signed.
- bwd_ready  out  1  backward element accepted when bwd_valid && bwd_ready.
- concat_vector  out  DATA_WIDTH x 2*HID_DIM (unpacked [0:2*HID_DIM-1])  FC1 input vector.
- start_fc1  out  1  one-cycle start pulse to the FC chain.
- fc_done  in  1  FC chain completion (driven from out_done_fc2).
- busy  out  1  high while a vector is launched or under FC computation.
- vec_count  out  CNT_WIDTH  number of vectors launched; wraps modulo 2^CNT_WIDTH.

Behaviour:

Reset (rst high at a clk edge):
- state=FILL, fwd_cnt=bwd_cnt=0, every concat_vector element=0.
- start_fc1=0, busy=0, vec_count=0.
- Reset mid-operation aborts everything with no start pulse. Partially filled data is discarded.

States: FILL, LAUNCH, WAIT_FC.

FILL:
- fwd_ready = (fwd_cnt < HID_DIM); bwd_ready = (bwd_cnt < HID_DIM). Both are combinational from registered state.
- Forward accept: concat_vector[fwd_cnt] <= fwd_data; fwd_cnt++.
- Backward accept: write index HID_DIM+bwd_cnt (BWD_REVERSE=0) or 2*HID_DIM-1-bwd_cnt (BWD_REVERSE=1); bwd_cnt++.
- Streams are fully independent. Both may be accepted in the same cycle. Either may finish first; that stream's ready then stays low.
- Transition to LAUNCH at the edge where the final pending element is accepted, i.e. the next-state counts are both HID_DIM. This includes the case where both last elements arrive together.

LAUNCH:
- Lasts exactly one cycle; start_fc1=1 and busy=1 during this cycle.
- Both readies are 0. vec_count increments at the exit edge.
- Next state is WAIT_FC.
- Latency: last accept at edge N -> start_fc1 high in the cycle after edge N.

WAIT_FC:
- busy=1, both readies 0, concat_vector held bit-stable.
- When fc_done=1 at an edge: fwd_cnt=bwd_cnt=0 and state=FILL.
- concat_vector keeps its old contents until it is overwritten element by element. Vector contents need not be cleared between frames.
- The first new accept is possible in the cycle after the fc_done edge.

Other rules:
- fc_done is ignored in FILL and LAUNCH.
- A fc_done that is high in the LAUNCH cycle is not captured; only fc_done sampled in WAIT_FC counts.
- Data on a stream with valid low is ignored. No writes occur without a handshake.
- No arithmetic is performed on data: elements are stored bit-exact, with no saturation or sign change.

Test Plan:
- Reset, then rst held for 3 cycles -> all concat_vector=0, start_fc1=0, busy=0, vec_count=0, fwd_ready=bwd_ready=1.
- Interleaved streams, fwd k = 16'h0100+k and bwd k = 16'h8000+k, both valid every cycle, fc_done tied 0.
  - Required: 100 cycles of dual accepts, then start_fc1 high exactly one cycle.
  - Required vector: [0]=0100, [99]=0163, [100]=8000, [199]=8063.
  - Required after launch: busy=1, vec_count=1, readies 0.
- Skewed arrival: all 100 fwd elements first, then bwd with random valid gaps.
  - Required: fwd_ready=0 after 100 forward accepts, while bwd_ready stays 1.
  - Required: a single start_fc1, one cycle after the 100th backward accept.
- BWD_REVERSE=1 with bwd k = k -> [199]=0000, [100]=0063.
- Back-pressure: with DUT in WAIT_FC, drive fwd_valid/bwd_valid high with data 16'hDEAD.
  - Required: no accept and vector unchanged.
  - Then pulse fc_done for 1 cycle -> readies return the next cycle.
  - Second frame -> vec_count=2; vec_count wraps 0xFFFF -> 0 when preloaded through 65536 frames or with CNT_WIDTH=2 (4 frames -> 0).
- Reset mid-fill after 50 fwd and 30 bwd accepts.
  - Required: counts cleared, no start_fc1.
  - Required: a full new frame then launches normally with vec_count=1.
